// File: rtl/gbe_tx_arbiter_if.sv
// 10GbE core TX port bundle: the arbiter drives the master side, the core the slave side.
interface gbe_tx_arbiter_if #(
   parameter int DATA_W = 64
);
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_end_of_frame;
   logic [31:0]       tx_dest_ip;
   logic [15:0]       tx_dest_port;
   logic              tx_afull;
   logic              tx_overflow;

   modport master (
      output tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
      input  tx_afull, tx_overflow
   );

   modport slave (
      input  tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
      output tx_afull, tx_overflow
   );
endinterface

// File: rtl/gbe_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the 10GbE core TX port between two show-ahead FIFO sources.
// Define GBE_TX_ARB_SRC_CNT_EN to add per-source completed-frame counters (src0_frames/src1_frames).
module gbe_tx_arbiter #(
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 11,
   parameter int MAX_WORDS = 1024,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clr,
   input  logic              src0_req,
   input  logic [LEN_W-1:0]  src0_len,
   input  logic [31:0]       src0_dest_ip,
   input  logic [15:0]       src0_dest_port,
   input  logic [DATA_W-1:0] src0_data,
   output logic              src0_grant,
   output logic              src0_rd,
   input  logic              src1_req,
   input  logic [LEN_W-1:0]  src1_len,
   input  logic [31:0]       src1_dest_ip,
   input  logic [15:0]       src1_dest_port,
   input  logic [DATA_W-1:0] src1_data,
   output logic              src1_grant,
   output logic              src1_rd,
   gbe_tx_arbiter_if.master  tx,
   output logic              busy,
   output logic              overflow_seen,
   output logic              len_err,
   output logic [CNT_W-1:0]  frames_sent
`ifdef GBE_TX_ARB_SRC_CNT_EN
   ,
   output logic [CNT_W-1:0]  src0_frames,
   output logic [CNT_W-1:0]  src1_frames
`endif
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   state_t             state_q, state_d;
   logic               ptr_q;
   logic               winner_q;
   logic [LEN_W-1:0]   remaining_q;
   logic [1:0]         grant_q;

   logic               pick;
   logic [LEN_W-1:0]   sel_len;
   logic [31:0]        sel_ip;
   logic [15:0]        sel_port;
   logic               len_ok;
   logic               start;
   logic               bad_len;
   logic               rd_en;

   always_comb begin
      pick = ptr_q;
      if (!(ptr_q ? src1_req : src0_req)) pick = ~ptr_q;
      sel_len  = pick ? src1_len       : src0_len;
      sel_ip   = pick ? src1_dest_ip   : src0_dest_ip;
      sel_port = pick ? src1_dest_port : src0_dest_port;
      len_ok   = (sel_len != '0) && (sel_len <= MAX_LEN);
      start    = 1'b0;
      bad_len  = 1'b0;
      rd_en    = 1'b0;
      state_d  = state_q;
      case (state_q)
         IDLE: begin
            if (enable && !tx.tx_afull && (src0_req || src1_req)) begin
               start   = 1'b1;
               bad_len = !len_ok;
               state_d = len_ok ? SEND : GAP;
            end
         end
         SEND: begin
            if (!tx.tx_afull) begin
               rd_en = 1'b1;
               if (remaining_q == LEN_W'(1)) state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant, destination and word count are captured together when a request wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         ptr_q           <= 1'b0;
         winner_q        <= 1'b0;
         remaining_q     <= '0;
         grant_q         <= '0;
         tx.tx_dest_ip   <= '0;
         tx.tx_dest_port <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= '0;
         if (start) begin
            winner_q        <= pick;
            grant_q         <= pick ? 2'b10 : 2'b01;
            remaining_q     <= sel_len;
            tx.tx_dest_ip   <= sel_ip;
            tx.tx_dest_port <= sel_port;
         end else if (rd_en) begin
            remaining_q <= remaining_q - LEN_W'(1);
         end
         if (state_q == GAP) ptr_q <= ~winner_q;
      end
   end

   assign src0_grant = grant_q[0];
   assign src1_grant = grant_q[1];
   assign src0_rd    = rd_en && !winner_q;
   assign src1_rd    = rd_en &&  winner_q;
   assign busy       = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx.tx_valid        <= 1'b0;
         tx.tx_data         <= '0;
         tx.tx_end_of_frame <= 1'b0;
      end else begin
         tx.tx_valid        <= rd_en;
         tx.tx_data         <= winner_q ? src1_data : src0_data;
         tx.tx_end_of_frame <= rd_en && (remaining_q == LEN_W'(1));
      end
   end

   // A set or count event in the same cycle as clr takes precedence over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_seen <= 1'b0;
         len_err       <= 1'b0;
         frames_sent   <= '0;
      end else begin
         overflow_seen <= tx.tx_overflow | (overflow_seen & ~clr);
         len_err       <= bad_len | (len_err & ~clr);
         if (tx.tx_end_of_frame) frames_sent <= (clr ? '0 : frames_sent) + CNT_W'(1);
         else if (clr)           frames_sent <= '0;
      end
   end

`ifdef GBE_TX_ARB_SRC_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src0_frames <= '0;
         src1_frames <= '0;
      end else begin
         if (tx.tx_end_of_frame && !winner_q) src0_frames <= (clr ? '0 : src0_frames) + CNT_W'(1);
         else if (clr)                        src0_frames <= '0;
         if (tx.tx_end_of_frame && winner_q)  src1_frames <= (clr ? '0 : src1_frames) + CNT_W'(1);
         else if (clr)                        src1_frames <= '0;
      end
   end
`endif

endmodule

// File: doc/gbe_tx_arbiter.md
Name: gbe_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 10GbE core TX port (tx_valid/tx_data/tx_end_of_frame/tx_dest_ip/tx_dest_port) between two packetised sources, e.g. the two GPU-bound streams.
- Each source holds its payload in a show-ahead FIFO and posts a request carrying word count and destination.
- The arbiter grants one source, drains exactly that many 64-bit words into the core, honours tx_afull back-pressure, and tags the last word with end-of-frame.

Parameters:
- DATA_W, 64, payload word width; must equal the core tx_data width.
- LEN_W, 11, width of the per-packet word-count field.
- MAX_WORDS, 1024, largest legal packet in words (8 KB jumbo).
- CNT_W, 32, width of the status counters.

Ports:
- clk  in  1  fabric clock, shared with the core's clk.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new grants are issued; a frame in flight completes.
- clr  in  1  synchronous clear of sticky flags and counters.
- src0_req  in  1  packet ready in source 0 FIFO; held until grant.
- src0_len  in  LEN_W  packet length in words; valid with req.
- src0_dest_ip  in  32  destination IP; valid with req.
- src0_dest_port  in  16  destination UDP port; valid with req.
- src0_data  in  DATA_W  show-ahead FIFO head word.
- src0_grant  out  1  one-cycle pulse; request consumed.
- src0_rd  out  1  FIFO pop strobe.
- src1_*: identical set for source 1.
- tx_valid  out  1  to core.
- tx_data  out  DATA_W  to core.
- tx_end_of_frame  out  1  to core.
- tx_dest_ip  out  32  to core.
- tx_dest_port  out  16  to core.
- tx_afull  in  1  from core.
- tx_overflow  in  1  from core.
- busy  out  1  high outside IDLE.
- overflow_seen  out  1  sticky; set when tx_overflow is seen.
- len_err  out  1  sticky; set on an illegal length.
- frames_sent  out  CNT_W  count of completed frames.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; priority pointer = 0.
  - All outputs are 0, including tx_dest_ip/port, the counters and the sticky flags.
- State machine:
  - IDLE -> SEND: when enable=1, tx_afull=0 and any req is high.
    - Winner: the requester at the priority pointer if it is requesting, else the other one.
    - Latch len, dest_ip and dest_port into registers that drive tx_dest_ip/tx_dest_port.
    - Pulse the winner's grant for 1 cycle and load remaining = len.
  - IDLE -> GAP (illegal length): if the latched len is 0 or exceeds MAX_WORDS.
    - Grant is still pulsed and no rd is issued.
    - Set len_err; no tx_valid is produced.
  - SEND: on each cycle with tx_afull=0, assert the winner's rd for 1 cycle and decrement remaining.
    - Each cycle with tx_afull=1, rd=0 and the state holds (pause).
    - The rd that takes remaining 1->0 is the last word; transition to GAP.
  - GAP: one idle cycle.
    - Priority pointer := the loser of the just-finished arbitration (strict alternation under contention).
    - Go to IDLE.
- Datapath latency: 1 cycle.
  - tx_valid(t+1) = rd(t).
  - tx_data(t+1) = granted src_data(t).
  - tx_end_of_frame(t+1) = 1 only for the last word.
- tx_dest_ip/port are stable from the first tx_valid through end_of_frame.
- The non-granted source never sees rd or grant.
- tx_afull asserting in the same cycle as the last word: that word is held; eof is emitted when tx_afull drops.
- Both requests arriving in the same cycle: the pointer decides; after reset source 0 wins.
- enable dropping mid-SEND: the frame finishes; IDLE then waits.
- frames_sent increments on each tx_end_of_frame and wraps modulo 2^CNT_W.
- clr clears overflow_seen, len_err and frames_sent. A set event in the same cycle wins over clr.
- Asynchronous reset mid-frame: abandons the frame with no eof.
  - Sources must flush their FIFOs on the same reset.
- Minimum inter-frame gap: 2 cycles (GAP + IDLE).

Optional Feature:
- Macro: GBE_TX_ARB_SRC_CNT_EN.
- When defined:
  - Adds outputs src0_frames and src1_frames (CNT_W each), per-source completed-frame counters.
  - Both count alongside frames_sent; cleared by clr and by reset.
  - Invariant: src0_frames + src1_frames == frames_sent, modulo 2^CNT_W.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Single source, src0_req with len=4, dest 0xC0A80514:0x2710, tx_afull=0:
  - grant 1 cycle later; four rd cycles; tx_valid on 4 consecutive cycles.
  - eof on the 4th word; frames_sent=1.
- Both req held, len=2 each:
  - grants alternate 0,1,0,1; each frame has 2 valid words.
  - frames are separated by ≥2 idle cycles; tx_dest tracks the granted source.
- Back-pressure: len=8, tx_afull high for 3 cycles after word 3:
  - no rd for those 3 cycles; exactly 8 tx_valid in total; data order preserved; eof on word 8.
- Illegal length: src1_len=0, then src1_len=1025:
  - grant pulses each time; zero tx_valid; len_err=1.
  - clr -> len_err=0.
- Reset in flight: rst_n low after word 2 of a len=6 frame:
  - all outputs 0 immediately.
  - after release, a new src0 len=1 frame is sent correctly and source 0 wins the first tie.
- tx_overflow pulsed 1 cycle -> overflow_seen=1, held until clr.
  - If GBE_TX_ARB_SRC_CNT_EN is defined, check src0_frames + src1_frames == frames_sent.
